imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Write-side counterpart of the instruction memory: the CPU datapath only reads
//  instruction words, and this block fills them. It receives a framed byte stream,
//  assembles 16-bit instruction words, and issues write strobes into the
//  instruction memory. It holds the CPU (pc/register state) until a frame with a
//  valid checksum has been fully written.
// PARAMETERS
//  ADDR_W     8   instruction memory address width (matches pc width)
//  INSTR_W    16  instruction word width; must be 16 (two bytes per word)
//  BASE_ADDR  0   first address written; addresses wrap mod 2**ADDR_W
// PORTS
//  clk         in   1        system clock, rising edge
//  rst         in   1        synchronous, active-high reset
//  start       in   1        1-cycle pulse: begin receiving a frame
//  byte_in     in   8        stream data byte
//  byte_valid  in   1        byte_in valid
//  byte_ready  out  1        loader accepts byte; transfer = byte_valid & byte_ready
//  imem_we     out  1        instruction memory write strobe (1 cycle per word)
//  imem_addr   out  ADDR_W   write address
//  imem_wdata  out  INSTR_W  write data, {hi_byte, lo_byte}
//  cpu_hold    out  1        1 = CPU must hold pc / suppress RegWrite, MemWrite
//  done        out  1        frame written, checksum good (level, until next start)
//  err         out  1        checksum mismatch (level, until next start)
// BEHAVIOUR
//  Frame: LEN byte L (word count, 0..255), then 2*L data bytes (per word: hi
//   byte = instr[15:8] first, then lo byte), then CHK = XOR of all 2*L data bytes.
//  Reset values: state=IDLE, byte_ready=0, imem_we=0, imem_addr=BASE_ADDR,
//   imem_wdata=0, cpu_hold=1, done=0, err=0, internal count=0, xor acc=0.
//  FSM: IDLE, LEN, HI, LO, CHK, DONE, ERR.
//   IDLE/DONE/ERR + start -> LEN; clears done, err, xor acc, word index;
//    sets cpu_hold=1. In any other state, start is ignored.
//   LEN  on transfer: latch L; L==0 -> CHK, else -> HI.
//   HI   on transfer: latch hi byte, acc ^= byte -> LO.
//   LO   on transfer: acc ^= byte; next cycle imem_we=1 with
//    imem_addr = BASE_ADDR + index (mod 2**ADDR_W), imem_wdata = {hi,lo};
//    index++; if index+1 == L -> CHK, else -> HI.
//   CHK  on transfer: byte == acc -> DONE (done=1, cpu_hold=0);
//    otherwise -> ERR (err=1, cpu_hold stays 1).
//  byte_ready = 1 exactly in LEN, HI, LO, CHK (combinational from state).
//   byte_valid without ready is not consumed.
//  Write latency: imem_we is registered; it is high in the cycle after the lo-byte
//   transfer, for exactly one cycle. Back-to-back bytes every cycle are supported;
//   the write of word k overlaps reception of word k+1.
//  Words already written stay in memory on ERR; memory is not rolled back.
//  rst mid-frame: returns to reset values immediately on the next edge; no
//   further imem_we; any partial frame is abandoned.
//  A word count (index) is 8 bits, so L=255 is the maximum frame.
// STRUCTURE
//  Shared package cpu_pkg: ADDR_W/INSTR_W constants and an enum loader_state_t
//   {IDLE,LEN,HI,LO,CHK,DONE,ERR}. The block is a single module with no
//   sub-modules. The frame checker is small enough to stay inline.
//  Top-level integration: cpu_hold gates the pc register enable and RegWrite/MemWrite.
//   An instruction memory write port (we, addr, wdata) is added beside the read port.
// TESTING
//  1 rst, start, stream 02,12,34,AB,CD,(12^34^AB^CD=40) -> writes [0]=1234,[1]=ABCD;
//    done=1, cpu_hold=0, err=0.
//  2 same frame with CHK=41 -> both writes occur; err=1, done=0, cpu_hold=1.
//  3 start, LEN=00, CHK=00 -> no imem_we; done=1. Then LEN=00, CHK=FF -> err=1.
//  4 BASE_ADDR=FE, L=3 -> writes at FE, FF, 00 (wrap); imem_we pulses exactly 3.
//  5 byte_valid toggled randomly / gaps between bytes -> identical memory contents
//    and status as the gap-free stream; start pulsed mid-frame is ignored.
//  6 rst asserted after the hi byte of word 1 -> no further writes;
//    all outputs at reset values; a fresh frame then loads correctly.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants and instruction loader state type
//
// Purpose: constants shared by the CPU datapath and the instruction memory
// loader, plus the loader FSM state enumeration.
// Ports: none (package).

package cpu_pkg;

  // Instruction memory address width; matches the pc width.
  localparam int CPU_ADDR_W  = 8;

  // Instruction word width; the loader assembles exactly two bytes per word.
  localparam int CPU_INSTR_W = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    HI   = 3'd2,
    LO   = 3'd3,
    CHK  = 3'd4,
    DONE = 3'd5,
    ERR  = 3'd6
  } loader_state_t;

endpackage

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte stream to instruction memory write port
//
// Purpose: receives a frame {LEN, 2*LEN data bytes (hi then lo per word), CHK},
// writes each assembled 16-bit word into instruction memory, and holds the CPU
// until a frame whose XOR checksum matches has been fully written.
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   start               1-cycle pulse: begin a frame (honoured in IDLE/DONE/ERR)
//   byte_in/byte_valid  stream byte and its valid
//   byte_ready          loader accepts a byte (LEN, HI, LO, CHK)
//   imem_we/addr/wdata  registered instruction memory write port
//   cpu_hold            1 = CPU holds pc and suppresses RegWrite/MemWrite
//   done / err          frame outcome levels, cleared by the next start

module imem_loader
  import cpu_pkg::*;
#(
  parameter int                ADDR_W    = CPU_ADDR_W,
  parameter int                INSTR_W   = CPU_INSTR_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [7:0]         byte_in,
  input  logic               byte_valid,
  output logic               byte_ready,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_hold,
  output logic               done,
  output logic               err
);

  loader_state_t      state_q, state_d;
  logic [7:0]         len_q,   len_d;
  logic [7:0]         idx_q,   idx_d;
  logic [7:0]         hi_q,    hi_d;
  logic [7:0]         acc_q,   acc_d;
  logic               we_q,    we_d;
  logic [ADDR_W-1:0]  addr_q,  addr_d;
  logic [INSTR_W-1:0] wdata_q, wdata_d;
  logic               hold_q,  hold_d;
  logic               done_q,  done_d;
  logic               err_q,   err_d;

  logic xfer;
  logic last_word;

  assign byte_ready = (state_q == LEN) || (state_q == HI) ||
                      (state_q == LO)  || (state_q == CHK);
  assign xfer       = byte_valid && byte_ready;

  // Widened compare so the test stays correct for the full 255-word frame.
  assign last_word  = ({1'b0, idx_q} + 9'd1) == {1'b0, len_q};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    hi_d    = hi_q;
    acc_d   = acc_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    done_d  = done_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = LEN;
          done_d  = 1'b0;
          err_d   = 1'b0;
          acc_d   = 8'h00;
          idx_d   = 8'h00;
          hold_d  = 1'b1;
        end
      end

      LEN: begin
        if (xfer) begin
          len_d   = byte_in;
          state_d = (byte_in == 8'h00) ? CHK : HI;
        end
      end

      HI: begin
        if (xfer) begin
          hi_d    = byte_in;
          acc_d   = acc_q ^ byte_in;
          state_d = LO;
        end
      end

      LO: begin
        if (xfer) begin
          acc_d   = acc_q ^ byte_in;
          // The write is registered, so it lands one cycle after the lo byte
          // and overlaps reception of the next word's hi byte.
          we_d    = 1'b1;
          addr_d  = BASE_ADDR + ADDR_W'(idx_q);
          wdata_d = INSTR_W'({hi_q, byte_in});
          idx_d   = idx_q + 8'd1;
          state_d = last_word ? CHK : HI;
        end
      end

      CHK: begin
        if (xfer) begin
          if (byte_in == acc_q) begin
            state_d = DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = ERR;
            err_d   = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= 8'h00;
      idx_q   <= 8'h00;
      hi_q    <= 8'h00;
      acc_q   <= 8'h00;
      we_q    <= 1'b0;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      hi_q    <= hi_d;
      acc_q   <= acc_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_hold   = hold_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
//
// Purpose: drives framed byte streams into two loaders (base 00 and base FE)
// and compares the logged memory writes and status against a frame model.
// Ports: none (top-level bench).

module tb_imem_loader;

  logic       clk = 1'b0;
  logic       rst, start, byte_valid;
  logic [7:0] byte_in;

  logic        ready0, we0, hold0, done0, err0;
  logic [7:0]  addr0;
  logic [15:0] wdata0;
  logic        ready1, we1, hold1, done1, err1;
  logic [7:0]  addr1;
  logic [15:0] wdata1;

  int total = 0;
  int bad   = 0;

  logic [23:0] log0[$];
  logic [23:0] log1[$];
  logic [15:0] words[256];

  always #5 clk = ~clk;

  imem_loader u_dut0 (
    .clk(clk), .rst(rst), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(ready0), .imem_we(we0), .imem_addr(addr0), .imem_wdata(wdata0),
    .cpu_hold(hold0), .done(done0), .err(err0)
  );

  imem_loader #(.BASE_ADDR(8'hFE)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(ready1), .imem_we(we1), .imem_addr(addr1), .imem_wdata(wdata1),
    .cpu_hold(hold1), .done(done1), .err(err1)
  );

  // Memory write monitor: imem_we is a register, so one sample per cycle.
  always @(negedge clk) begin
    if (we0) log0.push_back({addr0, wdata0});
    if (we1) log1.push_back({addr1, wdata1});
  end

  function automatic logic [7:0] model_chk(input int len);
    logic [7:0] c = 8'h00;
    for (int i = 0; i < len; i++) c = c ^ words[i][15:8] ^ words[i][7:0];
    return c;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n = 0;
    if (gaps) begin
      byte_valid = 1'b0;
      byte_in    = 8'($urandom);
      repeat ($urandom_range(0, 3)) step();
    end
    byte_in    = b;
    byte_valid = 1'b1;
    while (!ready0 && n < 20) begin
      step();
      n++;
    end
    total++;
    if (!ready0) begin
      bad++;
      $display("FAIL ready_wait: byte_ready=%0b required 1", ready0);
    end
    step();
    byte_valid = 1'b0;
  endtask

  task automatic send_frame(input int len, input logic [7:0] chk, input bit gaps,
                            input bit mid_start);
    log0.delete();
    log1.delete();
    pulse_start();
    send_byte(8'(len), gaps);
    for (int i = 0; i < len; i++) begin
      send_byte(words[i][15:8], gaps);
      send_byte(words[i][7:0], gaps);
      if (mid_start && i == 0) pulse_start();
    end
    send_byte(chk, gaps);
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    repeat (3) step();
    rst = 1'b0;
    step();
    total += 8;
    if (ready0 !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b required 0", ready0); end
    if (we0 !== 1'b0) begin bad++; $display("FAIL reset_we: got %b required 0", we0); end
    if (addr0 !== 8'h00) begin bad++; $display("FAIL reset_addr0: got %h required 00", addr0); end
    if (addr1 !== 8'hFE) begin bad++; $display("FAIL reset_addr1: got %h required fe", addr1); end
    if (wdata0 !== 16'h0000) begin bad++; $display("FAIL reset_wdata: got %h required 0000", wdata0); end
    if (hold0 !== 1'b1) begin bad++; $display("FAIL reset_hold: got %b required 1", hold0); end
    if (done0 !== 1'b0) begin bad++; $display("FAIL reset_done: got %b required 0", done0); end
    if (err0 !== 1'b0) begin bad++; $display("FAIL reset_err: got %b required 0", err0); end
  endtask

  task automatic test_basic();
    log0.delete();
    log1.delete();
    pulse_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    total += 3;
    if (we0 !== 1'b1) begin bad++; $display("FAIL latency_we0: got %b required 1", we0); end
    if (addr0 !== 8'h00) begin bad++; $display("FAIL latency_addr0: got %h required 00", addr0); end
    if (wdata0 !== 16'h1234) begin bad++; $display("FAIL latency_wdata0: got %h required 1234", wdata0); end
    send_byte(8'hAB, 1'b0);
    total++;
    if (we0 !== 1'b0) begin bad++; $display("FAIL we_one_cycle: got %b required 0", we0); end
    send_byte(8'hCD, 1'b0);
    send_byte(8'h40, 1'b0);
    step();
    total += 6;
    if (log0.size() !== 2) begin bad++; $display("FAIL basic_count: got %0d required 2", log0.size()); end
    else begin
      if (log0[0] !== 24'h00_1234) begin bad++; $display("FAIL basic_w0: got %h required 001234", log0[0]); end
      if (log0[1] !== 24'h01_ABCD) begin bad++; $display("FAIL basic_w1: got %h required 01abcd", log0[1]); end
    end
    if (done0 !== 1'b1) begin bad++; $display("FAIL basic_done: got %b required 1", done0); end
    if (hold0 !== 1'b0) begin bad++; $display("FAIL basic_hold: got %b required 0", hold0); end
    if (err0 !== 1'b0) begin bad++; $display("FAIL basic_err: got %b required 0", err0); end
    if (log1.size() !== 2 || log1[0] !== 24'hFE_1234 || log1[1] !== 24'hFF_ABCD) begin
      bad++;
      $display("FAIL basic_base_fe: got count %0d required FE/FF writes", log1.size());
    end
  endtask

  task automatic test_bad_chk();
    words[0] = 16'h1234;
    words[1] = 16'hABCD;
    send_frame(2, 8'h41, 1'b0, 1'b0);
    total += 4;
    if (log0.size() !== 2 || log0[0] !== 24'h00_1234 || log0[1] !== 24'h01_ABCD) begin
      bad++;
      $display("FAIL badchk_writes: got count %0d required 2 writes", log0.size());
    end
    if (err0 !== 1'b1) begin bad++; $display("FAIL badchk_err: got %b required 1", err0); end
    if (done0 !== 1'b0) begin bad++; $display("FAIL badchk_done: got %b required 0", done0); end
    if (hold0 !== 1'b1) begin bad++; $display("FAIL badchk_hold: got %b required 1", hold0); end
    // Valid bytes offered in ERR must not be consumed.
    byte_valid = 1'b1;
    byte_in    = 8'h05;
    repeat (3) step();
    byte_valid = 1'b0;
    step();
    total += 3;
    if (ready0 !== 1'b0) begin bad++; $display("FAIL err_ready: got %b required 0", ready0); end
    if (log0.size() !== 2) begin bad++; $display("FAIL err_no_write: got %0d required 2", log0.size()); end
    if (err0 !== 1'b1) begin bad++; $display("FAIL err_level: got %b required 1", err0); end
  endtask

  task automatic test_zero_len();
    send_frame(0, 8'h00, 1'b0, 1'b0);
    total += 3;
    if (log0.size() !== 0) begin bad++; $display("FAIL zero_writes: got %0d required 0", log0.size()); end
    if (done0 !== 1'b1) begin bad++; $display("FAIL zero_done: got %b required 1", done0); end
    if (hold0 !== 1'b0) begin bad++; $display("FAIL zero_hold: got %b required 0", hold0); end
    send_frame(0, 8'hFF, 1'b0, 1'b0);
    total += 3;
    if (err0 !== 1'b1) begin bad++; $display("FAIL zero_bad_err: got %b required 1", err0); end
    if (done0 !== 1'b0) begin bad++; $display("FAIL zero_bad_done: got %b required 0", done0); end
    if (log0.size() !== 0) begin bad++; $display("FAIL zero_bad_writes: got %0d required 0", log0.size()); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) words[i] = 16'($urandom);
    send_frame(3, model_chk(3), 1'b0, 1'b0);
    total++;
    if (log1.size() !== 3) begin
      bad++;
      $display("FAIL wrap_count: got %0d required 3", log1.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        logic [23:0] e;
        e = {8'(8'hFE + i), words[i]};
        total++;
        if (log1[i] !== e) begin bad++; $display("FAIL wrap_w%0d: got %h required %h", i, log1[i], e); end
      end
    end
    total++;
    if (done1 !== 1'b1) begin bad++; $display("FAIL wrap_done: got %b required 1", done1); end
  endtask

  task automatic test_gaps();
    for (int t = 0; t < 6; t++) begin
      int         len;
      bit         corrupt;
      logic [7:0] chk;
      len     = $urandom_range(1, 8);
      corrupt = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < len; i++) words[i] = 16'($urandom);
      chk = model_chk(len) ^ {7'd0, corrupt};
      for (int pass = 0; pass < 2; pass++) begin
        send_frame(len, chk, pass == 1, pass == 1);
        total++;
        if (log0.size() !== len) begin
          bad++;
          $display("FAIL gaps_count t%0d p%0d: got %0d required %0d", t, pass, log0.size(), len);
        end else begin
          for (int i = 0; i < len; i++) begin
            logic [23:0] e;
            e = {8'(i), words[i]};
            total++;
            if (log0[i] !== e) begin bad++; $display("FAIL gaps_w%0d t%0d p%0d: got %h required %h", i, t, pass, log0[i], e); end
          end
        end
        total += 3;
        if (done0 !== !corrupt) begin bad++; $display("FAIL gaps_done t%0d p%0d: got %b required %b", t, pass, done0, !corrupt); end
        if (err0 !== corrupt) begin bad++; $display("FAIL gaps_err t%0d p%0d: got %b required %b", t, pass, err0, corrupt); end
        if (hold0 !== corrupt) begin bad++; $display("FAIL gaps_hold t%0d p%0d: got %b required %b", t, pass, hold0, corrupt); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int errs = 0;
    for (int i = 0; i < 255; i++) words[i] = 16'($urandom);
    send_frame(255, model_chk(255), 1'b0, 1'b0);
    total++;
    if (log0.size() !== 255) begin
      bad++;
      $display("FAIL b2b_count: got %0d required 255", log0.size());
    end else begin
      for (int i = 0; i < 255; i++) begin
        if (log0[i] !== {8'(i), words[i]}) errs++;
        if (log1[i] !== {8'(8'hFE + i), words[i]}) errs++;
      end
      total++;
      if (errs != 0) begin bad++; $display("FAIL b2b_contents: got %0d wrong entries required 0", errs); end
    end
    total++;
    if (done0 !== 1'b1) begin bad++; $display("FAIL b2b_done: got %b required 1", done0); end
  endtask

  task automatic test_rst_mid();
    log0.delete();
    log1.delete();
    pulse_start();
    send_byte(8'h03, 1'b0);
    send_byte(8'h5A, 1'b0);
    send_byte(8'hC3, 1'b0);
    send_byte(8'h77, 1'b0);
    rst = 1'b1;
    step();
    total += 6;
    if (ready0 !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b required 0", ready0); end
    if (we0 !== 1'b0) begin bad++; $display("FAIL rst_we: got %b required 0", we0); end
    if (addr0 !== 8'h00) begin bad++; $display("FAIL rst_addr: got %h required 00", addr0); end
    if (wdata0 !== 16'h0000) begin bad++; $display("FAIL rst_wdata: got %h required 0000", wdata0); end
    if (hold0 !== 1'b1) begin bad++; $display("FAIL rst_hold: got %b required 1", hold0); end
    if (done0 !== 1'b0 || err0 !== 1'b0) begin bad++; $display("FAIL rst_status: got done=%b err=%b required 0 0", done0, err0); end
    rst        = 1'b0;
    byte_valid = 1'b1;
    byte_in    = 8'h99;
    repeat (4) step();
    byte_valid = 1'b0;
    step();
    total++;
    if (log0.size() !== 1 || log0[0] !== 24'h00_5AC3) begin
      bad++;
      $display("FAIL rst_writes: got count %0d required 1 write 005ac3", log0.size());
    end
    words[0] = 16'($urandom);
    words[1] = 16'($urandom);
    send_frame(2, model_chk(2), 1'b1, 1'b0);
    total += 2;
    if (log0.size() !== 2 || log0[0] !== {8'h00, words[0]} || log0[1] !== {8'h01, words[1]}) begin
      bad++;
      $display("FAIL rst_fresh_writes: got count %0d required 2 writes", log0.size());
    end
    if (done0 !== 1'b1) begin bad++; $display("FAIL rst_fresh_done: got %b required 1", done0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_chk();
    test_zero_len();
    test_wrap();
    test_gaps();
    test_back_to_back();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
